elevator_control_top: RTL and testbench
=======================================

ELEVATOR_CONTROL_TOP -- requirements
Module: elevator_control_top

Interface
REQ-001 SHALL have parameter DEPTH, default 8: request queue entries; power of two.
REQ-002 SHALL have parameter DOOR_CYCLES, default 4: cycles the door stays open when unobstructed.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous to clk and active-high.
REQ-005 SHALL have port requested_floor, input, 4: floor-call code; 0 = no request, 1..15 = floor number.
REQ-006 SHALL have port sensor, input, 1: door obstruction sensor; 1 = obstructed.
REQ-007 SHALL have port open_close_door, input, 1: manual door button.
REQ-008 SHALL have port current_floor, output, 4: floor the car is at (0..15).
REQ-009 SHALL have port elevator_direction, output, 1: 1 = up, 0 = down; holds its last value when stopped.
REQ-010 SHALL have port door_open, output, 1: 1 exactly while the state is DOOR_OPEN.

Function
REQ-011 SHALL hold a register last_requested_floor that is loaded with requested_floor every cycle.
REQ-012 SHALL push requested_floor into a circular FIFO (queue[], head, tail, count) on a cycle where requested_floor != 0 and requested_floor != last_requested_floor.
REQ-013 SHALL drop the push silently when the FIFO is full; head/tail SHALL wrap modulo DEPTH.
REQ-014 SHALL, on a simultaneous push and pop, leave count unchanged and move both pointers.
REQ-015 SHALL implement the states IDLE, MOVING_UP, MOVING_DOWN and DOOR_OPEN.
REQ-016 In IDLE with the FIFO non-empty, SHALL pop queue[head] into target at the next edge and go to one of:
- MOVING_UP (direction 1) if target > current_floor;
- MOVING_DOWN (direction 0) if target < current_floor;
- DOOR_OPEN if target = current_floor.
REQ-017 In MOVING_UP or MOVING_DOWN, SHALL step current_floor by +1 or -1 on every edge.
REQ-018 SHALL enter DOOR_OPEN on the same edge at which current_floor becomes equal to target; pending requests SHALL NOT be served en route.
REQ-019 On entering DOOR_OPEN, SHALL load the door timer with DOOR_CYCLES-1.
REQ-020 In DOOR_OPEN, SHALL apply, in priority order:
- sensor=1: reload the timer and stay;
- else open_close_door=1 or timer=0: go to IDLE;
- else: decrement the timer.
REQ-021 In IDLE with the FIFO empty and open_close_door=1, SHALL enter DOOR_OPEN with the timer loaded.
REQ-022 SHALL ignore open_close_door and sensor while moving; the door never opens between floors.
REQ-023 SHALL saturate current_floor to 0..15; floor 0 is the park/reset floor and cannot be requested.
REQ-024 SHALL accept requests in every state, including while the door is open or the car is moving.

Reset
REQ-025 On rst=1 at an edge, SHALL set the following:
- state = IDLE, current_floor = 0, elevator_direction = 1, door_open = 0;
- head = tail = count = 0, last_requested_floor = 0, target = 0, timer = 0.
REQ-026 Reset mid-move or mid-door SHALL abort immediately and discard all queued requests; queue contents need not be cleared.

Structure
REQ-027 SHALL place the state enum, the floor width (4) and the default DEPTH/DOOR_CYCLES in a shared package elevator_pkg.
REQ-028 SHALL implement the FIFO as one sub-module, elevator_req_fifo (push, pop, dout, empty, full); the FSM and datapath stay in the top.

Verification
REQ-029 Bench SHALL check reset: after rst, current_floor=0, direction=1, door_open=0, state=IDLE.
REQ-030 Bench SHALL check a single call:
- stimulus: requested_floor=3 sampled at edge E0, then 0;
- E1 pop with state MOVING_UP;
- floor 1, 2, 3 at E2, E3, E4;
- door_open=1 from E4 for 4 cycles, then IDLE.
REQ-031 Bench SHALL check a queued call: requested_floor 3, then 8 on the next cycle, with sensor held 1 for 100 ns.
- car stops at 3;
- door stays open while sensor=1;
- after sensor falls and 4 cycles pass, car moves up and reaches 8 with door_open=1.
REQ-032 Bench SHALL check moving down: from floor 8, request 1 -> direction=0, seven MOVING_DOWN steps, door opens at floor 1.
REQ-033 Bench SHALL check duplicates and overflow:
- requested_floor held at 5 for 10 cycles -> exactly one entry;
- 9 distinct calls while the door is obstructed -> count=8 and the 9th is dropped.
REQ-034 Bench SHALL check the manual door: idle and open_close_door=1 -> door_open next edge; pressing again while sensor=0 -> IDLE next edge.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator controller.
package elevator_pkg;

    localparam int FLOOR_W             = 4;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_DOOR_CYCLES = 4;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam floor_t FLOOR_MIN = floor_t'(0);
    localparam floor_t FLOOR_MAX = floor_t'(15);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MOVING_UP   = 2'd1,
        MOVING_DOWN = 2'd2,
        DOOR_OPEN   = 2'd3
    } state_t;

endpackage

// File: rtl/elevator_req_fifo.sv
// Circular request queue. DEPTH must be a power of two (>= 2) so the
// pointers wrap for free. A push into a full queue is dropped.
module elevator_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  queue [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = queue[head];

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) queue[tail] <= din;
    end

endmodule

// File: rtl/elevator_control_top.sv
// Single-car elevator controller: queued floor calls served strictly in
// arrival order, one floor per cycle, timed door with obstruction hold.
module elevator_control_top
    import elevator_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int DOOR_CYCLES = DEFAULT_DOOR_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOOR_W-1:0] requested_floor,
    input  logic               sensor,
    input  logic               open_close_door,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               elevator_direction,
    output logic               door_open
);

    localparam int TW = $clog2(DOOR_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);

    state_t               state;
    floor_t               target;
    floor_t               last_requested_floor;
    logic [TW-1:0]        timer;

    logic                 push;
    logic                 pop;
    floor_t               fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    floor_t               floor_up;
    floor_t               floor_dn;

    // A held call code is queued once: only a change to a non-zero code pushes.
    assign push = (requested_floor != '0) && (requested_floor != last_requested_floor);
    assign pop  = (state == IDLE) && !fifo_empty;

    // Saturating neighbours of the current floor.
    assign floor_up = (current_floor == FLOOR_MAX) ? FLOOR_MAX : current_floor + 1'b1;
    assign floor_dn = (current_floor == FLOOR_MIN) ? FLOOR_MIN : current_floor - 1'b1;

    elevator_req_fifo #(
        .DEPTH (DEPTH),
        .W     (FLOOR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (requested_floor),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Edge detector history for the call input.
    always_ff @(posedge clk) begin
        if (rst) last_requested_floor <= '0;
        else     last_requested_floor <= requested_floor;
    end

    // Car FSM with registered floor, direction and door outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            current_floor      <= '0;
            elevator_direction <= 1'b1;
            door_open          <= 1'b0;
            target             <= '0;
            timer              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        target <= fifo_dout;
                        if (fifo_dout > current_floor) begin
                            state              <= MOVING_UP;
                            elevator_direction <= 1'b1;
                        end else if (fifo_dout < current_floor) begin
                            state              <= MOVING_DOWN;
                            elevator_direction <= 1'b0;
                        end else begin
                            state     <= DOOR_OPEN;
                            door_open <= 1'b1;
                            timer     <= TIMER_LOAD;
                        end
                    end else if (open_close_door) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        timer     <= TIMER_LOAD;
                    end
                end
                MOVING_UP: begin
                    current_floor <= floor_up;
                    if (floor_up == target) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        timer     <= TIMER_LOAD;
                    end else if (current_floor == FLOOR_MAX) begin
                        // Unreachable target; park rather than spin at the top.
                        state <= IDLE;
                    end
                end
                MOVING_DOWN: begin
                    current_floor <= floor_dn;
                    if (floor_dn == target) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        timer     <= TIMER_LOAD;
                    end else if (current_floor == FLOOR_MIN) begin
                        state <= IDLE;
                    end
                end
                DOOR_OPEN: begin
                    if (sensor) begin
                        timer <= TIMER_LOAD;
                    end else if (open_close_door || timer == '0) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_control_top.sv
// Directed bench for elevator_control_top: reset, single call, queued call
// with obstruction, downward trip, manual door, duplicate suppression,
// mid-door reset and queue overflow.
module tb_elevator_control_top;
    import elevator_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] requested_floor;
    logic       sensor;
    logic       open_close_door;
    logic [3:0] current_floor;
    logic       elevator_direction;
    logic       door_open;

    int checks;
    int failures;

    elevator_control_top #(
        .DEPTH       (8),
        .DOOR_CYCLES (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .requested_floor    (requested_floor),
        .sensor             (sensor),
        .open_close_door    (open_close_door),
        .current_floor      (current_floor),
        .elevator_direction (elevator_direction),
        .door_open          (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_car(input string tag, input int st, input int fl, input int dir, input int dr);
        check({tag, " state"}, int'(dut.state), st);
        check({tag, " floor"}, int'(current_floor), fl);
        check({tag, " dir"},   int'(elevator_direction), dir);
        check({tag, " door"},  int'(door_open), dr);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        requested_floor = 4'd0;
        sensor          = 1'b0;
        open_close_door = 1'b0;

        // Reset
        step();
        step();
        rst = 1'b0;
        check_car("reset", int'(IDLE), 0, 1, 0);
        check("reset count", int'(dut.u_fifo.count), 0);

        // Single call to floor 3
        requested_floor = 4'd3;
        step();                                   // E0: pushed
        check("single E0 count", int'(dut.u_fifo.count), 1);
        check("single E0 state", int'(dut.state), int'(IDLE));
        requested_floor = 4'd0;
        step();                                   // E1: popped
        check_car("single E1", int'(MOVING_UP), 0, 1, 0);
        check("single E1 count", int'(dut.u_fifo.count), 0);
        step();
        check_car("single E2", int'(MOVING_UP), 1, 1, 0);
        step();
        check_car("single E3", int'(MOVING_UP), 2, 1, 0);
        step();
        check_car("single E4", int'(DOOR_OPEN), 3, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("single door held", int'(door_open), 1);
        end
        step();                                   // E8
        check_car("single E8", int'(IDLE), 3, 1, 0);

        // Queued calls 3 then 8 with the door obstructed for 10 cycles
        requested_floor = 4'd3;
        sensor          = 1'b1;
        step();                                   // Q0
        check("queued Q0 state", int'(dut.state), int'(IDLE));
        requested_floor = 4'd8;
        step();                                   // Q1: pop 3, push 8
        check_car("queued Q1", int'(DOOR_OPEN), 3, 1, 1);
        check("queued Q1 count", int'(dut.u_fifo.count), 1);
        requested_floor = 4'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("queued obstructed door", int'(door_open), 1);
        end
        sensor = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("queued timer door", int'(door_open), 1);
        end
        step();                                   // Q13
        check_car("queued Q13", int'(IDLE), 3, 1, 0);
        step();                                   // Q14: pop 8
        check_car("queued Q14", int'(MOVING_UP), 3, 1, 0);
        for (int f = 4; f < 8; f++) begin
            step();
            check_car("queued climb", int'(MOVING_UP), f, 1, 0);
        end
        step();                                   // Q19
        check_car("queued arrive", int'(DOOR_OPEN), 8, 1, 1);
        for (int i = 0; i < 3; i++) step();
        check("queued door last", int'(door_open), 1);
        step();
        check_car("queued closed", int'(IDLE), 8, 1, 0);

        // Downward trip 8 -> 1
        requested_floor = 4'd1;
        step();
        requested_floor = 4'd0;
        step();
        check_car("down start", int'(MOVING_DOWN), 8, 0, 0);
        for (int f = 7; f > 1; f--) begin
            step();
            check_car("down step", int'(MOVING_DOWN), f, 0, 0);
        end
        step();
        check_car("down arrive", int'(DOOR_OPEN), 1, 0, 1);
        open_close_door = 1'b1;
        step();
        check_car("down close", int'(IDLE), 1, 0, 0);

        // Manual door: open from idle, then close with a second press
        step();                                   // button still held: opens
        check_car("manual open", int'(DOOR_OPEN), 1, 0, 1);
        open_close_door = 1'b0;
        step();
        check("manual still open", int'(door_open), 1);
        open_close_door = 1'b1;
        step();
        check_car("manual close", int'(IDLE), 1, 0, 0);
        open_close_door = 1'b0;
        step();
        check("manual stays idle", int'(dut.state), int'(IDLE));

        // Duplicate suppression while the door is held open
        sensor          = 1'b1;
        open_close_door = 1'b1;
        step();
        check("dup door open", int'(dut.state), int'(DOOR_OPEN));
        open_close_door = 1'b0;
        requested_floor = 4'd5;
        for (int i = 0; i < 10; i++) step();
        check("dup count", int'(dut.u_fifo.count), 1);
        check("dup still open", int'(door_open), 1);
        requested_floor = 4'd0;

        // Reset mid-door discards the queue
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_car("midreset", int'(IDLE), 0, 1, 0);
        check("midreset count", int'(dut.u_fifo.count), 0);

        // Overflow: 9 distinct calls with the door obstructed
        open_close_door = 1'b1;
        step();
        check("ovf door open", int'(dut.state), int'(DOOR_OPEN));
        open_close_door = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            requested_floor = 4'(i);
            step();
            check("ovf count", int'(dut.u_fifo.count), (i < 8) ? i : 8);
        end
        requested_floor = 4'd0;
        step();
        check("ovf full", int'(dut.u_fifo.full), 1);
        sensor          = 1'b0;
        open_close_door = 1'b1;
        step();
        check("ovf closed", int'(dut.state), int'(IDLE));
        open_close_door = 1'b0;
        step();                                   // oldest entry (1) served first
        check_car("ovf pop", int'(MOVING_UP), 0, 1, 0);
        check("ovf target", int'(dut.target), 1);
        check("ovf count after pop", int'(dut.u_fifo.count), 7);
        step();
        check_car("ovf arrive", int'(DOOR_OPEN), 1, 1, 1);
        requested_floor = 4'd10;                  // refills the slot freed by the pop
        step();
        check("ovf refill", int'(dut.u_fifo.count), 8);
        requested_floor = 4'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
